// File: rtl/jtcop_obj_dma.sv
// jtcop_obj_dma: copies CPU object RAM into the back bank of a double-buffered
// object table and flips the drawer's bank at the first vertical blank after a copy.
module jtcop_obj_dma #(
  parameter int AW = 10,
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          LVBL,
  input  logic          dma_req,
  output logic          ram_cs,
  output logic [AW-1:0] ram_addr,
  input  logic [DW-1:0] ram_dout,
  input  logic          ram_ok,
  output logic [AW:0]   tbl_waddr,
  output logic [DW-1:0] tbl_wdata,
  output logic          tbl_we,
  output logic          tbl_bank,
  output logic          busy
);
  localparam logic [1:0] IDLE = 2'd0, FETCH = 2'd1, WRITE = 2'd2;
  logic [1:0]    r_st;
  logic          r_req, r_swap, r_first, r_lvbl, r_bank, r_busy;
  logic [AW-1:0] r_cnt;
  logic [AW:0]   r_waddr;
  logic [DW-1:0] r_wdata;
  logic          w_fall, w_start;
  assign w_fall    = r_lvbl & ~LVBL;
  assign w_start   = (r_st == IDLE) & r_req;
  assign ram_cs    = r_st == FETCH;
  assign tbl_we    = r_st == WRITE;
  assign ram_addr  = r_cnt;
  assign tbl_waddr = r_waddr;
  assign tbl_wdata = r_wdata;
  assign tbl_bank  = r_bank;
  assign busy      = r_busy;
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_st    <= IDLE;
      r_req   <= 1'b0;
      r_swap  <= 1'b0;
      r_first <= 1'b0;
      r_lvbl  <= 1'b1;
      r_bank  <= 1'b0;
      r_busy  <= 1'b0;
      r_cnt   <= '0;
      r_waddr <= '0;
      r_wdata <= '0;
    end else begin
      r_lvbl <= LVBL;
      r_req  <= dma_req | (r_req & ~w_start);
      case (r_st)
        IDLE:
          if (r_req) begin
            r_swap  <= 1'b0;
            r_cnt   <= '0;
            r_busy  <= 1'b1;
            r_first <= 1'b1;
            r_st    <= FETCH;
          end else if (w_fall && r_swap) begin
            r_bank <= ~r_bank;
            r_swap <= 1'b0;
          end
        FETCH: begin
          // an ack in the first request cycle may belong to a previous requester
          r_first <= 1'b0;
          if (!r_first && ram_ok) begin
            r_wdata <= ram_dout;
            r_waddr <= {~r_bank, r_cnt};
            r_st    <= WRITE;
          end
        end
        WRITE:
          if (&r_cnt) begin
            r_busy <= 1'b0;
            r_swap <= 1'b1;
            r_st   <= IDLE;
          end else begin
            r_cnt   <= r_cnt + 1'b1;
            r_first <= 1'b1;
            r_st    <= FETCH;
          end
        default: r_st <= IDLE;
      endcase
    end
  end
endmodule
